// File: rtl/tqvp_dlmiles_i2c_fifo_wm.sv
// TX/RX byte FIFO pair for the I2C peripheral.
// TX carries CPU data-register writes (data byte plus control bits) to the I2C FSM
// through a valid/ready handshake. RX carries received bytes back to the CPU.
// Each direction reports its occupancy level and raises a one-cycle watermark strobe:
// TX fires when the level falls to the low mark, RX when it rises to the high mark.
module tqvp_dlmiles_i2c_fifo_wm #(
    parameter int unsigned TX_WIDTH = 12,
    parameter int unsigned RX_WIDTH = 8,
    parameter int unsigned DEPTH    = 4,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_tx_i,
    input  logic                flush_rx_i,
    input  logic [TX_WIDTH-1:0] cpu_wr_data_i,
    input  logic                cpu_wr_stb_i,
    output logic [RX_WIDTH:0]   cpu_rd_data_o,
    input  logic                cpu_rd_stb_i,
    output logic [TX_WIDTH-1:0] tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    input  logic [RX_WIDTH-1:0] rx_data_i,
    input  logic                rx_valid_i,
    input  logic [CNT_W-1:0]    tx_wm_i,
    input  logic [CNT_W-1:0]    rx_wm_i,
    output logic [CNT_W-1:0]    tx_level_o,
    output logic [CNT_W-1:0]    rx_level_o,
    output logic                st_tx_overrun_o,
    output logic                st_tx_full_o,
    output logic                st_tx_empty_o,
    output logic                st_rx_overrun_o,
    output logic                st_rx_full_o,
    output logic                st_rx_empty_o,
    output logic                stb_tx_wm_o,
    output logic                stb_rx_wm_o
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(DEPTH);

    // ---------------- TX state ----------------
    logic [TX_WIDTH-1:0] tx_mem [DEPTH];
    logic [PTR_W-1:0]    tx_wr_ptr;
    logic [PTR_W-1:0]    tx_rd_ptr;
    logic [CNT_W-1:0]    tx_level_q;
    logic [CNT_W-1:0]    tx_level_nxt_c;
    logic                tx_overrun_q;
    logic                tx_full_c;
    logic                tx_empty_c;
    logic                tx_pop_c;
    logic                tx_push_ok_c;

    // ---------------- RX state ----------------
    logic [RX_WIDTH-1:0] rx_mem [DEPTH];
    logic [PTR_W-1:0]    rx_wr_ptr;
    logic [PTR_W-1:0]    rx_rd_ptr;
    logic [CNT_W-1:0]    rx_level_q;
    logic [CNT_W-1:0]    rx_level_nxt_c;
    logic                rx_overrun_q;
    logic                rx_full_c;
    logic                rx_empty_c;
    logic                rx_pop_c;
    logic                rx_push_ok_c;

    logic                stb_tx_wm_q;
    logic                stb_rx_wm_q;

    assign tx_full_c  = (tx_level_q == LVL_FULL);
    assign tx_empty_c = (tx_level_q == '0);
    assign rx_full_c  = (rx_level_q == LVL_FULL);
    assign rx_empty_c = (rx_level_q == '0);

    // TX handshake qualification and next level; a full FIFO still accepts a push when the head leaves
    always_comb begin
        tx_pop_c       = tx_ready_i && !tx_empty_c;
        tx_push_ok_c   = cpu_wr_stb_i && (!tx_full_c || tx_pop_c);
        tx_level_nxt_c = tx_level_q;
        if (flush_tx_i) begin
            tx_level_nxt_c = '0;
        end else if (tx_push_ok_c && !tx_pop_c) begin
            tx_level_nxt_c = tx_level_q + CNT_W'(1);
        end else if (tx_pop_c && !tx_push_ok_c) begin
            tx_level_nxt_c = tx_level_q - CNT_W'(1);
        end
    end

    // RX push/pop qualification and next level; reads of an empty FIFO are ignored
    always_comb begin
        rx_pop_c       = cpu_rd_stb_i && !rx_empty_c;
        rx_push_ok_c   = rx_valid_i && (!rx_full_c || rx_pop_c);
        rx_level_nxt_c = rx_level_q;
        if (flush_rx_i) begin
            rx_level_nxt_c = '0;
        end else if (rx_push_ok_c && !rx_pop_c) begin
            rx_level_nxt_c = rx_level_q + CNT_W'(1);
        end else if (rx_pop_c && !rx_push_ok_c) begin
            rx_level_nxt_c = rx_level_q - CNT_W'(1);
        end
    end

    // TX pointers, level and sticky overrun; flush wins over any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            tx_level_q   <= '0;
            tx_overrun_q <= 1'b0;
        end else if (flush_tx_i) begin
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            tx_level_q   <= '0;
            tx_overrun_q <= 1'b0;
        end else begin
            if (tx_push_ok_c) begin
                tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
            end
            if (tx_pop_c) begin
                tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
            end
            tx_level_q <= tx_level_nxt_c;
            if (cpu_wr_stb_i && !tx_push_ok_c) begin
                tx_overrun_q <= 1'b1;
            end
        end
    end

    // RX pointers, level and sticky overrun; a byte arriving at a full FIFO is dropped (keep oldest)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            rx_level_q   <= '0;
            rx_overrun_q <= 1'b0;
        end else if (flush_rx_i) begin
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            rx_level_q   <= '0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (rx_push_ok_c) begin
                rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
            end
            if (rx_pop_c) begin
                rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
            end
            rx_level_q <= rx_level_nxt_c;
            if (rx_valid_i && !rx_push_ok_c) begin
                rx_overrun_q <= 1'b1;
            end
        end
    end

    // TX storage write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (tx_push_ok_c && !flush_tx_i) begin
            tx_mem[tx_wr_ptr] <= cpu_wr_data_i;
        end
    end

    // RX storage write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (rx_push_ok_c && !flush_rx_i) begin
            rx_mem[rx_wr_ptr] <= rx_data_i;
        end
    end

    // Watermark crossing strobes; a TX flush is a real drop to zero, an RX flush never fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_tx_wm_q <= 1'b0;
            stb_rx_wm_q <= 1'b0;
        end else begin
            stb_tx_wm_q <= (tx_level_q > tx_wm_i) && (tx_level_nxt_c <= tx_wm_i);
            stb_rx_wm_q <= !flush_rx_i && (rx_level_q < rx_wm_i) && (rx_level_nxt_c >= rx_wm_i);
        end
    end

    assign tx_data_o       = tx_mem[tx_rd_ptr];
    assign tx_valid_o      = !tx_empty_c;
    assign cpu_rd_data_o   = rx_empty_c ? {1'b1, RX_WIDTH'(0)} : {1'b0, rx_mem[rx_rd_ptr]};
    assign tx_level_o      = tx_level_q;
    assign rx_level_o      = rx_level_q;
    assign st_tx_overrun_o = tx_overrun_q;
    assign st_tx_full_o    = tx_full_c;
    assign st_tx_empty_o   = tx_empty_c;
    assign st_rx_overrun_o = rx_overrun_q;
    assign st_rx_full_o    = rx_full_c;
    assign st_rx_empty_o   = rx_empty_c;
    assign stb_tx_wm_o     = stb_tx_wm_q;
    assign stb_rx_wm_o     = stb_rx_wm_q;

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_fifo_wm.sv
// Self-checking bench for the I2C TX/RX FIFO pair: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_tqvp_dlmiles_i2c_fifo_wm;

    localparam int unsigned TXW   = 12;
    localparam int unsigned RXW   = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_tx = 1'b0;
    logic             flush_rx = 1'b0;
    logic [TXW-1:0]   cpu_wr_data = '0;
    logic             cpu_wr_stb = 1'b0;
    logic [RXW:0]     cpu_rd_data;
    logic             cpu_rd_stb = 1'b0;
    logic [TXW-1:0]   tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic [RXW-1:0]   rx_data = '0;
    logic             rx_valid = 1'b0;
    logic [CNT_W-1:0] tx_wm = '0;
    logic [CNT_W-1:0] rx_wm = '0;
    logic [CNT_W-1:0] tx_level;
    logic [CNT_W-1:0] rx_level;
    logic             st_tx_overrun, st_tx_full, st_tx_empty;
    logic             st_rx_overrun, st_rx_full, st_rx_empty;
    logic             stb_tx_wm, stb_rx_wm;

    always #5 clk = ~clk;

    tqvp_dlmiles_i2c_fifo_wm #(
        .TX_WIDTH(TXW),
        .RX_WIDTH(RXW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_tx_i     (flush_tx),
        .flush_rx_i     (flush_rx),
        .cpu_wr_data_i  (cpu_wr_data),
        .cpu_wr_stb_i   (cpu_wr_stb),
        .cpu_rd_data_o  (cpu_rd_data),
        .cpu_rd_stb_i   (cpu_rd_stb),
        .tx_data_o      (tx_data),
        .tx_valid_o     (tx_valid),
        .tx_ready_i     (tx_ready),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .tx_wm_i        (tx_wm),
        .rx_wm_i        (rx_wm),
        .tx_level_o     (tx_level),
        .rx_level_o     (rx_level),
        .st_tx_overrun_o(st_tx_overrun),
        .st_tx_full_o   (st_tx_full),
        .st_tx_empty_o  (st_tx_empty),
        .st_rx_overrun_o(st_rx_overrun),
        .st_rx_full_o   (st_rx_full),
        .st_rx_empty_o  (st_rx_empty),
        .stb_tx_wm_o    (stb_tx_wm),
        .stb_rx_wm_o    (stb_rx_wm)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO contents as queues plus sticky flags and expected strobes
    logic [TXW-1:0] txq[$];
    logic [RXW-1:0] rxq[$];
    bit             m_tx_ovr = 1'b0;
    bit             m_rx_ovr = 1'b0;
    bit             m_tx_stb = 1'b0;
    bit             m_rx_stb = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [RXW:0] exp_rd;
        exp_rd = (rxq.size() == 0) ? {1'b1, 8'h00} : {1'b0, rxq[0]};
        check("tx_level", 32'(tx_level), 32'(txq.size()));
        check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
        if (txq.size() != 0) check("tx_data", 32'(tx_data), 32'(txq[0]));
        check("tx_full", 32'(st_tx_full), 32'(txq.size() == DEPTH));
        check("tx_empty", 32'(st_tx_empty), 32'(txq.size() == 0));
        check("tx_overrun", 32'(st_tx_overrun), 32'(m_tx_ovr));
        check("rx_level", 32'(rx_level), 32'(rxq.size()));
        check("cpu_rd_data", 32'(cpu_rd_data), 32'(exp_rd));
        check("rx_full", 32'(st_rx_full), 32'(rxq.size() == DEPTH));
        check("rx_empty", 32'(st_rx_empty), 32'(rxq.size() == 0));
        check("rx_overrun", 32'(st_rx_overrun), 32'(m_rx_ovr));
        check("stb_tx_wm", 32'(stb_tx_wm), 32'(m_tx_stb));
        check("stb_rx_wm", 32'(stb_rx_wm), 32'(m_rx_stb));
    endtask

    // Apply current inputs for one clock, advance the model, compare, then drop the strobes
    task automatic cycle();
        int tp, rp;
        bit full, pop;
        tp = txq.size();
        rp = rxq.size();
        if (flush_tx) begin
            txq.delete();
            m_tx_ovr = 1'b0;
        end else begin
            full = (txq.size() == DEPTH);
            pop  = tx_ready && (txq.size() != 0);
            if (pop) void'(txq.pop_front());
            if (cpu_wr_stb) begin
                if (!full || pop) txq.push_back(cpu_wr_data);
                else m_tx_ovr = 1'b1;
            end
        end
        if (flush_rx) begin
            rxq.delete();
            m_rx_ovr = 1'b0;
        end else begin
            full = (rxq.size() == DEPTH);
            pop  = cpu_rd_stb && (rxq.size() != 0);
            if (pop) void'(rxq.pop_front());
            if (rx_valid) begin
                if (!full || pop) rxq.push_back(rx_data);
                else m_rx_ovr = 1'b1;
            end
        end
        m_tx_stb = (tp > int'(tx_wm)) && (txq.size() <= int'(tx_wm));
        m_rx_stb = !flush_rx && (rp < int'(rx_wm)) && (rxq.size() >= int'(rx_wm));
        @(posedge clk);
        #1;
        check_all();
        cpu_wr_stb = 1'b0;
        cpu_rd_stb = 1'b0;
        rx_valid   = 1'b0;
        flush_tx   = 1'b0;
        flush_rx   = 1'b0;
    endtask

    task automatic push_tx(input logic [TXW-1:0] d);
        cpu_wr_data = d;
        cpu_wr_stb  = 1'b1;
        cycle();
    endtask

    task automatic push_rx(input logic [RXW-1:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        cycle();
    endtask

    initial begin
        int pulses;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("reset_rd_data", 32'(cpu_rd_data), 32'h100);
        @(negedge clk);
        rst_n = 1'b1;

        // Ordering and pointer wrap over three passes
        for (int pass = 0; pass < 3; pass++) begin
            tx_ready = 1'b0;
            for (int i = 1; i <= 4; i++) push_tx(TXW'(12'h100 + i));
            check("order_full_level", 32'(tx_level), 32'd4);
            tx_ready = 1'b1;
            for (int i = 1; i <= 4; i++) begin
                check("order_head", 32'(tx_data), 32'(12'h100 + i));
                cycle();
            end
            check("order_drained", 32'(tx_level), 32'd0);
            check("order_no_ovr", 32'(st_tx_overrun), 32'd0);
        end
        tx_ready = 1'b0;

        // TX overrun, then full push with simultaneous pop
        for (int i = 0; i < 4; i++) push_tx(TXW'(12'h0A0 + i));
        push_tx(12'h1AA);
        check("ovr_set", 32'(st_tx_overrun), 32'd1);
        check("ovr_head", 32'(tx_data), 32'h0A0);
        tx_ready = 1'b1;
        push_tx(12'h1BB);
        tx_ready = 1'b0;
        check("ovr_pop_push_level", 32'(tx_level), 32'd4);
        check("ovr_pop_push_head", 32'(tx_data), 32'h0A1);

        // Flush beats a same-cycle push, and clears overrun
        flush_tx = 1'b1;
        push_tx(12'h1CC);
        check("flush_level", 32'(tx_level), 32'd0);
        check("flush_ovr", 32'(st_tx_overrun), 32'd0);
        check("flush_valid", 32'(tx_valid), 32'd0);

        // RX keep-oldest on overflow, then reads past empty
        for (int i = 1; i <= 5; i++) push_rx(RXW'(8'h11 * i));
        check("rx_ovr_set", 32'(st_rx_overrun), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            check("rx_head", 32'(cpu_rd_data), (i <= 4) ? 32'(8'h11 * i) : 32'h100);
            cpu_rd_stb = 1'b1;
            cycle();
        end
        flush_rx = 1'b1;
        cycle();

        // TX low watermark: single pulse on 2 -> 1
        tx_wm = 3'd1;
        for (int i = 0; i < 4; i++) push_tx(TXW'($urandom));
        pulses = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (stb_tx_wm) pulses++;
        end
        tx_ready = 1'b0;
        check("tx_wm_pulses", 32'(pulses), 32'd1);

        // RX high watermark: single pulse on 2 -> 3
        rx_wm = 3'd3;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) push_rx(RXW'($urandom));
            else cycle();
            if (stb_rx_wm) pulses++;
        end
        check("rx_wm_pulses", 32'(pulses), 32'd1);
        flush_rx = 1'b1;
        cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cpu_wr_data = TXW'($urandom);
            cpu_wr_stb  = ($urandom_range(0, 99) < 55);
            tx_ready    = ($urandom_range(0, 99) < 45);
            rx_data     = RXW'($urandom);
            rx_valid    = ($urandom_range(0, 99) < 50);
            cpu_rd_stb  = ($urandom_range(0, 99) < 45);
            flush_tx    = ($urandom_range(0, 63) == 0);
            flush_rx    = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 31) == 0) tx_wm = CNT_W'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) rx_wm = CNT_W'($urandom_range(0, 7));
            cycle();
        end
        tx_ready = 1'b0;
        tx_wm    = 3'd0;
        rx_wm    = 3'd0;

        // Async reset between edges with both FIFOs half full
        flush_tx = 1'b1;
        flush_rx = 1'b1;
        cycle();
        push_tx(12'h0F1);
        push_tx(12'h0F2);
        push_rx(8'hE1);
        push_rx(8'hE2);
        #2;
        rst_n = 1'b0;
        #1;
        txq.delete();
        rxq.delete();
        m_tx_ovr = 1'b0;
        m_rx_ovr = 1'b0;
        m_tx_stb = 1'b0;
        m_rx_stb = 1'b0;
        check_all();
        check("async_rd_data", 32'(cpu_rd_data), 32'h100);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        push_tx(12'h155);
        check("post_reset_head", 32'(tx_data), 32'h155);
        check("post_reset_level", 32'(tx_level), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
